btc_prog_ctrl: RTL
==================

# btc_prog_ctrl

Bitchain programming controller sitting directly upstream of the bitchain configuration shift register. Accepts host bitstream words over a valid/ready stream, slices each word into chain-width chunks and drives the chain's data and enable inputs, one chunk per enabled cycle, until exactly the configured number of chunks has been shifted. Optionally packs the chain's shifted-out contents back into words for readback and verification.

## Interface
- `WIDTH`, 1: chain width in bits; must divide `WORD_WIDTH`.
- `WORD_WIDTH`, 32: host word width.
- `CHAIN_CHUNKS`, 8: total `WIDTH`-bit shifts per programming pass (chain depth, ≥1).
- `clk` in 1: clock, the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `prog_start` in 1: single-cycle request to begin a programming pass.
- `prog_busy` out 1: high from the cycle after an accepted start until `prog_done`.
- `prog_done` out 1: one-cycle pulse at end of pass.
- `w_data` in `WORD_WIDTH`: bitstream word.
- `w_valid` in 1 / `w_ready` out 1: word handshake; transfer on the edge where both are high.
- `cfg_i` out `WIDTH`: chunk to chain input.
- `cfg_e` out 1: chain shift enable.
- `cfg_o` in `WIDTH`: chain output (deepest stage).
- `rd_data` out `WORD_WIDTH`, `rd_valid` out 1, `rd_ready` in 1: readback stream.

## Operation
- K = `WORD_WIDTH`/`WIDTH` chunks per word; the number of words consumed per pass is ceil(`CHAIN_CHUNKS`/K).
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `w_ready`=0, `cfg_e`=0. `prog_start`=1 → LOAD; remaining-chunk counter ← `CHAIN_CHUNKS`.
- LOAD: `w_ready`=1. On a word transfer: word buffer ← `w_data`; sub-counter ← min(K, remaining) → SHIFT. If `w_valid`=0, the FSM waits and `cfg_e` stays 0.
- SHIFT: `cfg_e`=1, `cfg_i`=buffer[`WIDTH`-1:0]. On each enabled edge:
  - buffer shifts right by `WIDTH`;
  - both counters decrement.
  - When the sub-counter reaches 0: go to LOAD if remaining > 0, otherwise go to DONE.
- Chunk order: word bits [`WIDTH`-1:0] are shifted first, so they end at the deepest chain stage when the chain depth equals `CHAIN_CHUNKS`.
- Final word: chunks beyond `CHAIN_CHUNKS` are discarded and never driven.
- DONE: `prog_done`=1 for one cycle, then IDLE.
- `prog_start` while not in IDLE is ignored; it has no effect on counters.
- Counters are width `$clog2(CHAIN_CHUNKS+1)`; they never wrap.
- Reset mid-pass: all outputs return to reset values immediately. Chain contents are left partial (the chain has no reset). A new `prog_start` begins a full pass.

## Timing
- Reset values:
  - state IDLE;
  - `w_ready`, `cfg_e`, `prog_busy`, `prog_done`, `rd_valid` = 0;
  - `cfg_i`, `rd_data` = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- `prog_start` high at edge 0 → `prog_busy`=`w_ready`=1 in cycle 1.
- Word accepted at edge t → `cfg_e`=1 in cycles t+1 … t+n (n = chunks of that word); `w_ready` high again in cycle t+n+1. This is one bubble per word.
- Last chunk's edge at t → `prog_done` and DONE in cycle t+1; `prog_busy`=0 and IDLE in cycle t+2.

## Configuration
- `BTC_PROG_READBACK_EN` defined:
  - Each enabled edge captures `cfg_o` into a pack register, filling from the LSB in the same order as the write slicing.
  - After K captures, or after the final chunk, `rd_data` ← packed word with unused upper bits zero, and `rd_valid`=1 until `rd_ready`.
  - While `rd_valid`=1 and `rd_ready`=0, the next capture would need the pack register, so `cfg_e` is forced to 0 and SHIFT stalls.
  - DONE is entered only after the final readback word is accepted.
- `BTC_PROG_READBACK_EN` undefined: no capture logic; `rd_valid`=0, `rd_data`=0, `rd_ready` and `cfg_o` are ignored.

## Structure
- Package `btc_prog_pkg`: state enum (IDLE/LOAD/SHIFT/DONE) and localparam helpers for K and counter widths.
- One sub-module, `btc_prog_rdpack` (readback packer, instantiated only under the macro).

## Test plan
All scenarios use `WIDTH`=4, `WORD_WIDTH`=32, `CHAIN_CHUNKS`=10, with a chain model attached.
- Reset → all outputs 0, state IDLE, `w_ready`=0.
- Start, then words 0x76543210 and 0xFFFFFFBA with `w_valid` held high:
  - `cfg_i` = 0,1,…,7, then A,B over 10 enabled cycles;
  - one bubble cycle between the two words;
  - one `prog_done` pulse; no third word requested.
- Gap in `w_valid` of 5 cycles before word 2 → `cfg_e` stays 0 for the gap; final chain contents are identical to the scenario above.
- `prog_start` pulsed during SHIFT → ignored; exactly 10 enabled cycles and one `prog_done`.
- `rst_n` low after 5 chunks:
  - outputs return to 0 immediately;
  - a fresh pass then shifts the full 10 chunks.
- Readback (macro on), chain preloaded with chunks 0x9,0x8,…,0x0 (deepest first):
  - `rd_data` = 0x23456789, then 0x00000001;
  - holding `rd_ready`=0 for 3 cycles stalls `cfg_e` for those 3 cycles.

Source files
------------

// File: rtl/btc_prog_pkg.sv
// Shared definitions for the bitchain programming controller: FSM encoding
// and the sizing helpers used by the controller and the readback packer.
package btc_prog_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        LOAD  = S_LOAD,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } btc_prog_state_e;

    // Chunks carried by one host word.
    function automatic int chunks_per_word(input int word_width, input int width);
        return word_width / width;
    endfunction

    // Counter width able to hold 0..chunks without wrapping.
    function automatic int cnt_width(input int chunks);
        return (chunks < 1) ? 1 : $clog2(chunks + 1);
    endfunction

endpackage

// File: rtl/btc_prog_rdpack.sv
// Readback packer: collects chain output chunks LSB-first into words and
// presents them on a valid/ready stream. Only built with BTC_PROG_READBACK_EN.
module btc_prog_rdpack
    import btc_prog_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap,
    input  logic [WIDTH-1:0]      cap_data,
    input  logic                  cap_last,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready
);

    localparam int K  = chunks_per_word(WORD_WIDTH, WIDTH);
    localparam int IW = cnt_width(K);

    logic [IW-1:0]         idx_q;
    logic [WORD_WIDTH-1:0] pack_q;
    logic [WORD_WIDTH-1:0] pack_nxt;
    logic                  flush;

    always_comb begin
        pack_nxt = pack_q;
        pack_nxt[idx_q*WIDTH +: WIDTH] = cap_data;
    end

    // A short final word flushes early; its unused upper chunks stay zero.
    assign flush = cap && ((idx_q == IW'(K - 1)) || cap_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            pack_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            if (flush) begin
                rd_data  <= pack_nxt;
                rd_valid <= 1'b1;
                pack_q   <= '0;
                idx_q    <= '0;
            end else if (cap) begin
                pack_q <= pack_nxt;
                idx_q  <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: rtl/btc_prog_ctrl.sv
// Bitchain programming controller: slices host words into chain-width chunks
// and shifts exactly CHAIN_CHUNKS of them. Readback enabled by BTC_PROG_READBACK_EN.
module btc_prog_ctrl
    import btc_prog_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_CHUNKS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_start,
    output logic                  prog_busy,
    output logic                  prog_done,
    input  logic [WORD_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [WIDTH-1:0]      cfg_i,
    output logic                  cfg_e,
    input  logic [WIDTH-1:0]      cfg_o,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready
);

    localparam int K  = chunks_per_word(WORD_WIDTH, WIDTH);
    localparam int CW = cnt_width(CHAIN_CHUNKS);

`ifdef BTC_PROG_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    btc_prog_state_e       state_q;
    logic [CW-1:0]         rem_q;
    logic [CW-1:0]         sub_q;
    logic [CW-1:0]         sub_load;
    logic [WORD_WIDTH-1:0] buf_q;
    logic                  shift_en;
    logic                  rd_stall;
    logic                  drain_ok;

    // min(K, remaining): the final word may carry fewer useful chunks.
    assign sub_load = (32'(rem_q) > K) ? CW'(K) : rem_q;

    assign shift_en  = (state_q == SHIFT) && (sub_q != '0) && !rd_stall;

    assign w_ready   = (state_q == LOAD);
    assign cfg_e     = shift_en;
    assign cfg_i     = buf_q[WIDTH-1:0];
    assign prog_busy = (state_q != IDLE);
    assign prog_done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sub_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (prog_start) begin
                        rem_q   <= CW'(CHAIN_CHUNKS);
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_valid) begin
                        buf_q   <= w_data;
                        sub_q   <= sub_load;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        buf_q <= buf_q >> WIDTH;
                        sub_q <= sub_q - CW'(1);
                        rem_q <= rem_q - CW'(1);
                        if (sub_q == CW'(1)) begin
                            // With readback, hold in SHIFT (sub=0) until the last word drains.
                            if (rem_q != CW'(1)) begin
                                state_q <= LOAD;
                            end else begin
                                state_q <= RB_EN ? SHIFT : DONE;
                            end
                        end
                    end else if (drain_ok) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BTC_PROG_READBACK_EN
    btc_prog_rdpack #(
        .WIDTH      (WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_rdpack (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap      (shift_en),
        .cap_data (cfg_o),
        .cap_last (shift_en && (rem_q == CW'(1))),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready)
    );

    // Stall on the registered rd_valid alone so rd_ready never reaches cfg_e.
    assign rd_stall = rd_valid;
    assign drain_ok = (sub_q == '0) && rd_valid && rd_ready;
`else
    logic unused_rb;

    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
    assign rd_stall  = 1'b0;
    assign drain_ok  = 1'b0;
    assign unused_rb = ^{rd_ready, cfg_o};
`endif

endmodule
